// File: rtl/riscv_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_arbiter_if
// Purpose  : Bundles the fetch port, the load/store port and the unified
//            memory handshake seen by riscv_mem_arbiter.
//            slave  = arbiter side, master = requesters and memory side.
// Revision : 1.0  initial release
// ============================================================================
interface riscv_mem_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic [DW-1:0] if_rdata_o;
    logic          if_ready_o;
    logic          d_rd_i;
    logic          d_wr_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic [DW-1:0] d_rdata_o;
    logic          d_ready_o;
    logic          stall_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_ack_i;
    logic          err_o;

    modport slave (
        input  if_req_i, if_addr_i, d_rd_i, d_wr_i, d_addr_i, d_wdata_i,
               mem_rdata_i, mem_ack_i,
        output if_rdata_o, if_ready_o, d_rdata_o, d_ready_o, stall_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i, d_rd_i, d_wr_i, d_addr_i, d_wdata_i,
               mem_rdata_i, mem_ack_i,
        input  if_rdata_o, if_ready_o, d_rdata_o, d_ready_o, stall_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_arbiter
// Purpose  : Shares one single-port memory between instruction fetch and
//            load/store. Data side has fixed priority (older instruction).
//            Each access is IDLE -> BUSY_x -> RESP; the ready pulse in RESP
//            returns the result and releases the pipeline stall.
// Options  : RISCV_MEM_ARB_TIMEOUT_EN - abort an access after TIMEOUT BUSY
//            cycles without ack, pulsing err_o with the ready pulse.
// Revision : 1.0  initial release
// ============================================================================
module riscv_mem_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    riscv_mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state_q,     state_d;
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] d_rdata_q,   d_rdata_d;
    logic          if_ready_q,  if_ready_d;
    logic          d_ready_q,   d_ready_d;

    logic          d_req;
    logic          busy;
    logic          timeout_hit;
    logic [DW-1:0] capture_data;

    assign d_req = bus.d_rd_i | bus.d_wr_i;
    assign busy  = (state_q == BUSY_D) || (state_q == BUSY_I);

`ifdef RISCV_MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt_q;
    logic          err_q;

    // Count un-acked BUSY cycles; the last one allowed is TIMEOUT-1.
    assign timeout_hit = busy && (wait_cnt_q == CW'(TIMEOUT - 1));

    // Wait counter restarts in IDLE (i.e. at BUSY entry); err flags an abort.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == IDLE)
                wait_cnt_q <= '0;
            else if (busy && !bus.mem_ack_i)
                wait_cnt_q <= wait_cnt_q + 1'b1;
            err_q <= busy && !bus.mem_ack_i && timeout_hit;
        end
    end

    assign bus.err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.err_o   = 1'b0;
`endif

    // An ack in the terminal timeout cycle wins, so only abort without ack.
    assign capture_data = bus.mem_ack_i ? bus.mem_rdata_i : '0;

    // Next-state and next-register values; everything defaults to hold.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_wr_i;
                    mem_addr_d  = bus.d_addr_i;
                    mem_wdata_d = bus.d_wdata_i;
                end else if (bus.if_req_i) begin
                    state_d    = BUSY_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr_i;
                end
            end
            BUSY_D, BUSY_I: begin
                if (bus.mem_ack_i || timeout_hit) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == BUSY_I) begin
                        if_rdata_d = capture_data;
                        if_ready_d = 1'b1;
                    end else begin
                        // Stores leave the load data register untouched.
                        if (!mem_we_q)
                            d_rdata_d = capture_data;
                        d_ready_d = 1'b1;
                    end
                end
            end
            RESP: begin
                // Requests are not sampled here so requesters can advance.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; async reset aborts any access in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.if_ready_o  = if_ready_q;
    assign bus.d_ready_o   = d_ready_q;

    // Stall while a request waits for its ready pulse; forced low in reset.
    assign bus.stall_o = rst_i & ((bus.if_req_i & ~if_ready_q) |
                                  (d_req & ~d_ready_q));

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mem_arbiter
// Purpose  : Directed self-checking bench for riscv_mem_arbiter. Expected
//            responses are queued when a request is driven and popped when
//            a ready pulse appears.
// Revision : 1.0  initial release
// ============================================================================
module tb_riscv_mem_arbiter;
    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;

    riscv_mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    riscv_mem_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    passed = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic void expect_resp(input logic is_d, input logic [31:0] rd, input logic err);
        resp_t r;
        r.is_d  = is_d;
        r.rdata = rd;
        r.err   = err;
        exp_q.push_back(r);
    endfunction

    // Wait (bounded) for a ready pulse, then compare it with the oldest expectation.
    task automatic check_resp(input int max);
        logic  found;
        resp_t e;
        found = 1'b0;
        for (int i = 0; i <= max && !found; i++) begin
            if (bus.if_ready_o || bus.d_ready_o) found = 1'b1;
            else step();
        end
        chk("resp_seen", {31'd0, found}, 32'd1);
        if (found) begin
            chk("resp_queued", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("resp_one_hot", {31'd0, bus.if_ready_o & bus.d_ready_o}, 32'd0);
                chk("resp_port", {31'd0, bus.d_ready_o}, {31'd0, e.is_d});
                chk("resp_rdata", bus.d_ready_o ? bus.d_rdata_o : bus.if_rdata_o, e.rdata);
                chk("resp_err", {31'd0, bus.err_o}, {31'd0, e.err});
            end
        end
    endtask

    initial begin
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.d_rd_i      = 1'b0;
        bus.d_wr_i      = 1'b0;
        bus.d_addr_i    = '0;
        bus.d_wdata_i   = '0;
        bus.mem_rdata_i = '0;
        bus.mem_ack_i   = 1'b0;

        // ---- reset state ----
        repeat (3) step();
        chk("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_ready", {30'd0, bus.if_ready_o, bus.d_ready_o}, 32'd0);
        chk("rst_err", {31'd0, bus.err_o}, 32'd0);
        rst = 1'b1;
        step();

        // ---- zero-wait fetch ----
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h100;
        expect_resp(1'b0, 32'h0050_0093, 1'b0);
        #1;
        chk("fetch_stall_req", {31'd0, bus.stall_o}, 32'd1);
        step();
        chk("fetch_mem_req", {31'd0, bus.mem_req_o}, 32'd1);
        chk("fetch_mem_addr", bus.mem_addr_o, 32'h100);
        chk("fetch_mem_we", {31'd0, bus.mem_we_o}, 32'd0);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h0050_0093;
        step();
        chk("fetch_if_ready", {31'd0, bus.if_ready_o}, 32'd1);
        chk("fetch_stall_done", {31'd0, bus.stall_o}, 32'd0);
        check_resp(1);
        bus.mem_ack_i = 1'b0;
        bus.if_req_i  = 1'b0;
        step();
        chk("fetch_pulse_end", {31'd0, bus.if_ready_o}, 32'd0);

        // ---- conflict: data wins, fetch follows ----
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h100;
        bus.d_rd_i    = 1'b1;
        bus.d_addr_i  = 32'h200;
        expect_resp(1'b1, 32'h1111_2222, 1'b0);
        expect_resp(1'b0, 32'h3333_4444, 1'b0);
        step();
        chk("conf_addr_d", bus.mem_addr_o, 32'h200);
        chk("conf_we_d", {31'd0, bus.mem_we_o}, 32'd0);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h1111_2222;
        step();
        check_resp(1);
        bus.mem_ack_i = 1'b0;
        bus.d_rd_i    = 1'b0;
        step();
        chk("conf_idle_req", {31'd0, bus.mem_req_o}, 32'd0);
        step();
        chk("conf_req_i", {31'd0, bus.mem_req_o}, 32'd1);
        chk("conf_addr_i", bus.mem_addr_o, 32'h100);
        chk("conf_we_i", {31'd0, bus.mem_we_o}, 32'd0);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h3333_4444;
        step();
        check_resp(1);
        chk("conf_d_rdata_hold", bus.d_rdata_o, 32'h1111_2222);
        bus.mem_ack_i = 1'b0;
        bus.if_req_i  = 1'b0;
        step();

        // ---- store with 3 wait states ----
        bus.d_wr_i    = 1'b1;
        bus.d_addr_i  = 32'h40;
        bus.d_wdata_i = 32'hDEAD_BEEF;
        expect_resp(1'b1, 32'h1111_2222, 1'b0);
        step();
        for (int c = 1; c <= 4; c++) begin
            chk("st_mem_req", {31'd0, bus.mem_req_o}, 32'd1);
            chk("st_mem_we", {31'd0, bus.mem_we_o}, 32'd1);
            chk("st_mem_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
            chk("st_no_ready", {31'd0, bus.d_ready_o}, 32'd0);
            if (c == 4) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = 32'h9999_9999;
            end
            step();
        end
        chk("st_req_drop", {31'd0, bus.mem_req_o}, 32'd0);
        chk("st_we_drop", {31'd0, bus.mem_we_o}, 32'd0);
        check_resp(1);
        bus.mem_ack_i = 1'b0;
        bus.d_wr_i    = 1'b0;
        step();

        // ---- read and write both high: treated as a write ----
        bus.d_rd_i    = 1'b1;
        bus.d_wr_i    = 1'b1;
        bus.d_addr_i  = 32'h80;
        bus.d_wdata_i = 32'h0000_0055;
        expect_resp(1'b1, 32'h1111_2222, 1'b0);
        step();
        chk("rw_mem_we", {31'd0, bus.mem_we_o}, 32'd1);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h1234_5678;
        step();
        check_resp(1);
        bus.mem_ack_i = 1'b0;
        bus.d_rd_i    = 1'b0;
        bus.d_wr_i    = 1'b0;
        step();

        // ---- load dropped mid-access still completes; address is registered ----
        bus.d_rd_i   = 1'b1;
        bus.d_addr_i = 32'h60;
        expect_resp(1'b1, 32'hCAFE_F00D, 1'b0);
        step();
        bus.d_rd_i   = 1'b0;
        bus.d_addr_i = 32'hFFF0;
        step();
        chk("drop_req_held", {31'd0, bus.mem_req_o}, 32'd1);
        chk("drop_addr_held", bus.mem_addr_o, 32'h60);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hCAFE_F00D;
        step();
        check_resp(1);
        bus.mem_ack_i = 1'b0;
        step();

        // ---- spurious ack in IDLE ----
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hBAD0_BAD0;
        repeat (2) begin
            step();
            chk("spur_ready", {30'd0, bus.if_ready_o, bus.d_ready_o}, 32'd0);
            chk("spur_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        end
        chk("spur_addr", bus.mem_addr_o, 32'h60);
        chk("spur_d_rdata", bus.d_rdata_o, 32'hCAFE_F00D);
        chk("spur_if_rdata", bus.if_rdata_o, 32'h3333_4444);
        bus.mem_ack_i = 1'b0;
        step();

        // ---- asynchronous reset mid fetch ----
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h300;
        step();
        chk("ar_busy_req", {31'd0, bus.mem_req_o}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("ar_if_rdata", bus.if_rdata_o, 32'd0);
        chk("ar_d_rdata", bus.d_rdata_o, 32'd0);
        chk("ar_ready", {30'd0, bus.if_ready_o, bus.d_ready_o}, 32'd0);
        chk("ar_stall", {31'd0, bus.stall_o}, 32'd0);
        bus.mem_ack_i = 1'b1;
        step();
        bus.mem_ack_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("ar_rel_req0", {31'd0, bus.mem_req_o}, 32'd0);
        expect_resp(1'b0, 32'h0000_ABCD, 1'b0);
        step();
        chk("ar_rel_req1", {31'd0, bus.mem_req_o}, 32'd1);
        chk("ar_rel_addr", bus.mem_addr_o, 32'h300);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h0000_ABCD;
        step();
        check_resp(1);
        bus.mem_ack_i = 1'b0;
        bus.if_req_i  = 1'b0;
        step();

`ifdef RISCV_MEM_ARB_TIMEOUT_EN
        // ---- timeout: load never acked ----
        bus.d_rd_i   = 1'b1;
        bus.d_addr_i = 32'h500;
        expect_resp(1'b1, 32'd0, 1'b1);
        step();
        for (int c = 1; c <= TIMEOUT; c++) begin
            chk("to_req_held", {31'd0, bus.mem_req_o}, 32'd1);
            step();
        end
        chk("to_req_drop", {31'd0, bus.mem_req_o}, 32'd0);
        chk("to_d_ready", {31'd0, bus.d_ready_o}, 32'd1);
        check_resp(0);
        bus.d_rd_i = 1'b0;
        step();
        chk("to_err_pulse_end", {31'd0, bus.err_o}, 32'd0);

        // ---- ack on the terminal cycle wins ----
        bus.d_rd_i   = 1'b1;
        bus.d_addr_i = 32'h504;
        expect_resp(1'b1, 32'h7777_8888, 1'b0);
        step();
        repeat (TIMEOUT - 1) step();
        chk("to15_req_held", {31'd0, bus.mem_req_o}, 32'd1);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h7777_8888;
        step();
        chk("to15_d_ready", {31'd0, bus.d_ready_o}, 32'd1);
        check_resp(0);
        bus.mem_ack_i = 1'b0;
        bus.d_rd_i    = 1'b0;
        step();
`endif

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
